// File: rtl/mux_pkg.sv
// Shared tag constants for the 4-to-1 arbitrated mux and its downstream 1-to-4 demux.
// Also holds the default data width and an index-to-tag helper.
package mux_pkg;

  localparam int unsigned ANCHO_DEF = 4;

  localparam logic [2:0] SEL_A = 3'b000;
  localparam logic [2:0] SEL_B = 3'b001;
  localparam logic [2:0] SEL_C = 3'b010;
  localparam logic [2:0] SEL_D = 3'b011;

  function automatic logic [2:0] sel_de_indice(input logic [1:0] idx);
    logic [2:0] sel;
    unique case (idx)
      2'd0:    sel = SEL_A;
      2'd1:    sel = SEL_B;
      2'd2:    sel = SEL_C;
      default: sel = SEL_D;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/arbitro_rr4.sv
// Combinational 4-way rotating-priority arbiter: the search starts at ptr_i and wraps mod 4.
// Produces a one-hot grant, its index, and whether any request was found.
module arbitro_rr4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_any_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_o     = 4'b0000;
    gnt_idx_o = 2'd0;
    gnt_any_o = 1'b0;
    cand      = 2'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_i + 2'(k);
      if (!gnt_any_o && req_i[cand]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (gnt_any_o) begin
      gnt_o = 4'b0001 << gnt_idx_o;
    end
  end

endmodule

// File: rtl/mux_arbitro_4a1.sv
// Merges four valid/ready channels into one registered, source-tagged stream.
// Define MUX_PRIORIDAD_FIJA_EN for fixed priority A > B > C > D instead of round robin.
module mux_arbitro_4a1
  import mux_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] a_data,
  input  logic [ANCHO-1:0] b_data,
  input  logic [ANCHO-1:0] c_data,
  input  logic [ANCHO-1:0] d_data,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
  output logic [ANCHO-1:0] y_data,
  output logic [2:0]       y_sel,
  output logic             y_valid,
  input  logic             y_ready
);

  logic [ANCHO-1:0] y_data_q, y_data_d;
  logic [2:0]       y_sel_q, y_sel_d;
  logic             y_valid_q, y_valid_d;

  logic [1:0] ptr;
  logic [3:0] req, gnt, ready_vec;
  logic [1:0] gnt_idx;
  logic       gnt_any;
  logic       carga;
  logic       xfer;
  logic [ANCHO-1:0] data_sel;

  assign req = {d_valid, c_valid, b_valid, a_valid};

  arbitro_rr4 u_arbitro (
    .req_i     (req),
    .ptr_i     (ptr),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Output slot is free, or is being drained on this edge.
  assign carga = !y_valid_q || y_ready;

  // Readies are held low while reset is asserted, regardless of register state.
  assign ready_vec = gnt & {4{carga && rst_n}};
  assign xfer      = gnt_any && carga && rst_n;

  assign a_ready = ready_vec[0];
  assign b_ready = ready_vec[1];
  assign c_ready = ready_vec[2];
  assign d_ready = ready_vec[3];

  always_comb begin
    data_sel = a_data;
    unique case (gnt_idx)
      2'd0:    data_sel = a_data;
      2'd1:    data_sel = b_data;
      2'd2:    data_sel = c_data;
      default: data_sel = d_data;
    endcase
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_sel_d   = y_sel_q;
    if (carga) begin
      y_valid_d = xfer;
      if (xfer) begin
        y_data_d = data_sel;
        y_sel_d  = sel_de_indice(gnt_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_sel_q   <= SEL_A;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_sel_q   <= y_sel_d;
    end
  end

`ifdef MUX_PRIORIDAD_FIJA_EN
  // Search always starts at A, so A starves the rest when held valid.
  assign ptr = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  assign y_data  = y_data_q;
  assign y_sel   = y_sel_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_arbitro_4a1.sv
// Directed bench for mux_arbitro_4a1; expectations follow MUX_PRIORIDAD_FIJA_EN when defined.
module tb_mux_arbitro_4a1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_data, b_data, c_data, d_data;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [3:0] y_data;
  logic [2:0] y_sel;
  logic       y_valid;
  logic       y_ready;

  int vectors = 0;
  int errors  = 0;

  mux_arbitro_4a1 #(.ANCHO(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_data  (a_data),
    .b_data  (b_data),
    .c_data  (c_data),
    .d_data  (d_data),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .c_valid (c_valid),
    .d_valid (d_valid),
    .a_ready (a_ready),
    .b_ready (b_ready),
    .c_ready (c_ready),
    .d_ready (d_ready),
    .y_data  (y_data),
    .y_sel   (y_sel),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_y(input string tag, input logic v, input logic [2:0] s, input logic [3:0] d);
    check({tag, "_valid"}, {7'd0, y_valid}, {7'd0, v});
    check({tag, "_sel"}, {5'd0, y_sel}, {5'd0, s});
    check({tag, "_data"}, {4'd0, y_data}, {4'd0, d});
  endtask

  task automatic check_rdy(input string tag, input logic [3:0] exp);
    check(tag, {4'd0, d_ready, c_ready, b_ready, a_ready}, {4'd0, exp});
  endtask

  logic [2:0] exp_rr_sel [6];
  logic [3:0] exp_rr_dat [6];
  logic [2:0] exp_ab_sel [4];
  logic [3:0] exp_ab_rdy [4];

  initial begin
`ifdef MUX_PRIORIDAD_FIJA_EN
    exp_rr_sel = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_rr_dat = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_ab_sel = '{3'b000, 3'b000, 3'b000, 3'b000};
    exp_ab_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_rr_sel = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b001};
    exp_rr_dat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_ab_sel = '{3'b000, 3'b001, 3'b000, 3'b001};
    exp_ab_rdy = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif

    // Reset held 3 cycles with every channel requesting.
    rst_n   = 1'b0;
    y_ready = 1'b1;
    a_data = 4'b0001; b_data = 4'b0010; c_data = 4'b0100; d_data = 4'b1000;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_rdy("rst_ready", 4'b0000);
    end
    check_y("rst", 1'b0, 3'b000, 4'b0000);

    // Single channel C; ptr = 0 so search A,B,C finds C.
    a_valid = 1'b0; b_valid = 1'b0; d_valid = 1'b0;
    c_data  = 4'b1011;
    rst_n   = 1'b1;
    #1;
    check_rdy("c_only_ready", 4'b0100);
    tick();
    check_y("c_only", 1'b1, 3'b010, 4'b1011);

    // Drain to idle, then a single D word, then idle again.
    c_valid = 1'b0;
    tick();
    check_y("idle0", 1'b0, 3'b010, 4'b1011);
    d_valid = 1'b1;
    #1;
    check_rdy("d_only_ready", 4'b1000);
    tick();
    check_y("d_only", 1'b1, 3'b011, 4'b1000);
    d_valid = 1'b0;
    tick();
    check_y("idle1", 1'b0, 3'b011, 4'b1000);

    // Round robin with all four valid; after D the search restarts at A.
    c_data  = 4'b0100;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_y("rr", 1'b1, exp_rr_sel[i], exp_rr_dat[i]);
    end

    // Idle, then load 1011 from A and apply backpressure with B requesting.
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
    tick();
    check_y("idle2", 1'b0, exp_rr_sel[5], exp_rr_dat[5]);
    a_valid = 1'b1;
    a_data  = 4'b1011;
    tick();
    check_y("bp_load", 1'b1, 3'b000, 4'b1011);
    a_valid = 1'b0;
    b_valid = 1'b1;
    y_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rdy("bp_ready", 4'b0000);
      tick();
      check_y("bp_hold", 1'b1, 3'b000, 4'b1011);
    end
    y_ready = 1'b1;
    #1;
    check_rdy("bp_release_ready", 4'b0010);
    tick();
    check_y("bp_release", 1'b1, 3'b001, 4'b0010);
    b_valid = 1'b0;
    tick();
    check_y("idle3", 1'b0, 3'b001, 4'b0010);

    // Reset mid-operation drops a held word and restarts ptr at 0.
    a_valid = 1'b1;
    a_data  = 4'b0101;
    y_ready = 1'b0;
    tick();
    check_y("pre_rst", 1'b1, 3'b000, 4'b0101);
    a_valid = 1'b0;
    rst_n   = 1'b0;
    tick();
    check_y("mid_rst", 1'b0, 3'b000, 4'b0000);

    // A and B both valid: alternation under round robin, A only under fixed priority.
    rst_n   = 1'b1;
    y_ready = 1'b1;
    a_data  = 4'b0001;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rdy("ab_ready", exp_ab_rdy[i]);
      tick();
      check_y("ab", 1'b1, exp_ab_sel[i], (exp_ab_sel[i] == 3'b000) ? 4'b0001 : 4'b0010);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
